// File: rtl/decode_mc_pkg.sv
// Shared types and constants for the multicycle controller decoder.
package decode_mc_pkg;

  // Main controller states
  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECUTER,
    EXECUTEI,
    MULEX,
    ALUWB,
    BRANCH
  } state_t;

  // ALU operation codes (zero-extended to the ALUControl width)
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_ORR = 4'b0101;
  localparam logic [3:0] ALU_EOR = 4'b0110;
  localparam logic [3:0] ALU_MOV = 4'b0111;
  localparam logic [3:0] ALU_BIC = 4'b1000;
  localparam logic [3:0] ALU_MUL = 4'b1001;

  // Datapath mux selects
  localparam logic [1:0] SRCA_REG   = 2'b00;
  localparam logic [1:0] SRCA_PC    = 2'b01;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Instruction class (Op field)
  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  // Data-processing opcodes (Funct[4:1])
  localparam logic [3:0] FN_AND = 4'b0000;
  localparam logic [3:0] FN_EOR = 4'b0001;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_ADD = 4'b0100;
  localparam logic [3:0] FN_TST = 4'b1000;
  localparam logic [3:0] FN_TEQ = 4'b1001;
  localparam logic [3:0] FN_CMP = 4'b1010;
  localparam logic [3:0] FN_CMN = 4'b1011;
  localparam logic [3:0] FN_ORR = 4'b1100;
  localparam logic [3:0] FN_MOV = 4'b1101;
  localparam logic [3:0] FN_BIC = 4'b1110;

endpackage

// File: rtl/decode_mc_mainfsm.sv
// Main multicycle FSM: state register, multiply latency counter and the
// per-state control output table.
module mainfsm_mc
  import decode_mc_pkg::*;
#(
  parameter int MUL_LATENCY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic       immOp,
  input  logic       loadOp,
  input  logic       IsMul,
  input  logic       dpNoWrite,
  input  logic       dpIllegal,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       aluOp,
  output logic       mulActive,
  output logic       MulStart,
  output logic       Illegal,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB
);

  localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 1);

  state_t     state;
  state_t     next;
  logic [3:0] mulCount;

  // State register; reset always lands in FETCH
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next;
  end

  // Multiply counter: loaded on MULEX entry, counts down to the exit point
  always_ff @(posedge clk) begin
    if (reset)                                mulCount <= 4'd0;
    else if (state == DECODE && next == MULEX) mulCount <= MUL_LOAD;
    else if (state == MULEX && mulCount != 4'd0) mulCount <= mulCount - 4'd1;
  end

  // Illegal flag: captured while decoding, dropped once the next fetch completes
  always_ff @(posedge clk) begin
    if (reset)                 Illegal <= 1'b0;
    else if (state == DECODE)  Illegal <= (Op == OP_UNDEF) || (Op == OP_DP && !IsMul && dpIllegal);
    else if (state == FETCH)   Illegal <= 1'b0;
  end

  // Next-state selection and Moore output table
  always_comb begin
    next      = FETCH;
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    aluOp     = 1'b0;
    mulActive = 1'b0;
    MulStart  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_REG;
    ALUSrcB   = SRCB_REG;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        next      = DECODE;
      end
      DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        case (Op)
          OP_MEM:  next = MEMADR;
          OP_BR:   next = BRANCH;
          OP_DP:   next = IsMul ? MULEX : (immOp ? EXECUTEI : EXECUTER);
          default: next = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB = SRCB_IMM;
        next    = loadOp ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        next   = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
        next      = FETCH;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
        next   = FETCH;
      end
      EXECUTER, EXECUTEI: begin
        aluOp   = 1'b1;
        ALUSrcB = (state == EXECUTEI) ? SRCB_IMM : SRCB_REG;
        next    = (dpNoWrite || dpIllegal) ? FETCH : ALUWB;
      end
      MULEX: begin
        mulActive = 1'b1;
        MulStart  = (mulCount == MUL_LOAD);
        next      = (mulCount == 4'd0) ? ALUWB : MULEX;
      end
      ALUWB: begin
        RegW = 1'b1;
        next = FETCH;
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        Branch    = 1'b1;
        next      = FETCH;
      end
      default: next = FETCH;
    endcase
  end

endmodule

// File: rtl/decode_mc.sv
// Multicycle controller decoder top: main FSM plus ALU decoder, flag-write
// and PC-write logic and instruction-field decode.
module decode_mc
  import decode_mc_pkg::*;
#(
  parameter int ALUCTL_W    = 4,
  parameter int MUL_LATENCY = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          Op,
  input  logic [5:0]          Funct,
  input  logic [3:0]          Rd,
  input  logic                IsMul,
  output logic [1:0]          FlagW,
  output logic                PCS,
  output logic                NextPC,
  output logic                RegW,
  output logic                MemW,
  output logic                IRWrite,
  output logic                AdrSrc,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ImmSrc,
  output logic [1:0]          RegSrc,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic                MulStart,
  output logic                Illegal
);

  logic       branch;
  logic       aluOp;
  logic       mulActive;
  logic [3:0] dpCode;
  logic       dpNoWrite;
  logic       dpIllegal;
  logic       dpArith;
  logic [3:0] aluCode;

  mainfsm_mc #(.MUL_LATENCY(MUL_LATENCY)) u_fsm (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .immOp     (Funct[5]),
    .loadOp    (Funct[0]),
    .IsMul     (IsMul),
    .dpNoWrite (dpNoWrite),
    .dpIllegal (dpIllegal),
    .IRWrite   (IRWrite),
    .NextPC    (NextPC),
    .AdrSrc    (AdrSrc),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (branch),
    .aluOp     (aluOp),
    .mulActive (mulActive),
    .MulStart  (MulStart),
    .Illegal   (Illegal),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB)
  );

  // Data-processing opcode table: ALU code, writeback suppression, legality
  always_comb begin
    dpCode    = ALU_ADD;
    dpNoWrite = 1'b0;
    dpIllegal = 1'b0;
    case (Funct[4:1])
      FN_ADD: dpCode = ALU_ADD;
      FN_SUB: dpCode = ALU_SUB;
      FN_AND: dpCode = ALU_AND;
      FN_ORR: dpCode = ALU_ORR;
      FN_EOR: dpCode = ALU_EOR;
      FN_MOV: dpCode = ALU_MOV;
      FN_BIC: dpCode = ALU_BIC;
      FN_CMP: begin dpCode = ALU_SUB; dpNoWrite = 1'b1; end
      FN_CMN: begin dpCode = ALU_ADD; dpNoWrite = 1'b1; end
      FN_TST: begin dpCode = ALU_AND; dpNoWrite = 1'b1; end
      FN_TEQ: begin dpCode = ALU_EOR; dpNoWrite = 1'b1; end
      default: dpIllegal = 1'b1;
    endcase
    dpArith = (dpCode == ALU_ADD) || (dpCode == ALU_SUB);
  end

  // ALU control and flag-write enables; only live in execute or multiply states
  always_comb begin
    aluCode = ALU_ADD;
    FlagW   = 2'b00;
    if (aluOp) begin
      if (!dpIllegal) begin
        aluCode = dpCode;
        if (dpNoWrite) FlagW = {1'b1, dpArith};
        else           FlagW = {Funct[0], Funct[0] & dpArith};
      end
    end else if (mulActive) begin
      aluCode = ALU_MUL;
      FlagW   = {Funct[0], 1'b0};
    end
  end

  assign ALUControl = ALUCTL_W'(aluCode);
  assign PCS        = ((Rd == 4'd15) && RegW) || branch;
  assign ImmSrc     = Op;
  assign RegSrc     = (Op == OP_MEM) ? 2'b10 : ((Op == OP_DP) ? 2'b00 : 2'b01);

endmodule

// File: tb/tb_decode_mc.sv
// Self-checking bench for decode_mc: two instances (multiply latency 3 with a
// 4-bit ALUControl, latency 1 with a 5-bit ALUControl) against an
// instruction-level reference model.
module tb_decode_mc;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       IsMul;

  logic [1:0] FlagW3, ResultSrc3, ALUSrcA3, ALUSrcB3, ImmSrc3, RegSrc3;
  logic       PCS3, NextPC3, RegW3, MemW3, IRWrite3, AdrSrc3, MulStart3, Illegal3;
  logic [3:0] ALUControl3;
  logic [1:0] FlagW1, ResultSrc1, ALUSrcA1, ALUSrcB1, ImmSrc1, RegSrc1;
  logic       PCS1, NextPC1, RegW1, MemW1, IRWrite1, AdrSrc1, MulStart1, Illegal1;
  logic [4:0] ALUControl1;

  decode_mc #(.ALUCTL_W(4), .MUL_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .IsMul(IsMul),
    .FlagW(FlagW3), .PCS(PCS3), .NextPC(NextPC3), .RegW(RegW3), .MemW(MemW3),
    .IRWrite(IRWrite3), .AdrSrc(AdrSrc3), .ResultSrc(ResultSrc3), .ALUSrcA(ALUSrcA3),
    .ALUSrcB(ALUSrcB3), .ImmSrc(ImmSrc3), .RegSrc(RegSrc3), .ALUControl(ALUControl3),
    .MulStart(MulStart3), .Illegal(Illegal3)
  );

  decode_mc #(.ALUCTL_W(5), .MUL_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .IsMul(IsMul),
    .FlagW(FlagW1), .PCS(PCS1), .NextPC(NextPC1), .RegW(RegW1), .MemW(MemW1),
    .IRWrite(IRWrite1), .AdrSrc(AdrSrc1), .ResultSrc(ResultSrc1), .ALUSrcA(ALUSrcA1),
    .ALUSrcB(ALUSrcB1), .ImmSrc(ImmSrc1), .RegSrc(RegSrc1), .ALUControl(ALUControl1),
    .MulStart(MulStart1), .Illegal(Illegal1)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Flag masks for the top byte of an expected-output vector
  localparam logic [7:0] F_IRW  = 8'h80;
  localparam logic [7:0] F_NPC  = 8'h40;
  localparam logic [7:0] F_ADR  = 8'h20;
  localparam logic [7:0] F_REGW = 8'h10;
  localparam logic [7:0] F_MEMW = 8'h08;
  localparam logic [7:0] F_PCS  = 8'h04;
  localparam logic [7:0] F_MS   = 8'h02;
  localparam logic [7:0] F_ILL  = 8'h01;

  typedef struct {
    string       name;
    logic [24:0] v;
    bit          c3;
    bit          c1;
  } rec_t;

  rec_t        expq[$];
  logic [24:0] obs3q[$];
  logic [24:0] obs1q[$];
  int          tests = 0;
  int          fails = 0;
  bit          sync1 = 1'b1;
  bit          carry = 1'b0;

  function automatic logic [24:0] obs3();
    return {IRWrite3, NextPC3, AdrSrc3, RegW3, MemW3, PCS3, MulStart3, Illegal3,
            ResultSrc3, ALUSrcA3, ALUSrcB3, ImmSrc3, RegSrc3, FlagW3, 1'b0, ALUControl3};
  endfunction

  function automatic logic [24:0] obs1();
    return {IRWrite1, NextPC1, AdrSrc1, RegW1, MemW1, PCS1, MulStart1, Illegal1,
            ResultSrc1, ALUSrcA1, ALUSrcB1, ImmSrc1, RegSrc1, FlagW1, ALUControl1};
  endfunction

  function automatic logic [24:0] mk(input logic [7:0] fl, input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] imm, input logic [1:0] rsrc,
                                     input logic [1:0] fw, input logic [3:0] alu);
    return {fl, rs, sa, sb, imm, rsrc, fw, 1'b0, alu};
  endfunction

  function automatic void push(input string n, input logic [24:0] v, input bit c3, input bit c1);
    expq.push_back('{name: n, v: v, c3: c3, c1: c1});
  endfunction

  // Instruction semantics of the data-processing opcodes
  function automatic void dp_info(input logic [3:0] f4, output logic [3:0] code, output bit nw,
                                  output bit legal, output bit arith);
    code = 4'h0; nw = 1'b0; legal = 1'b1; arith = 1'b0;
    case (f4)
      4'b0100: begin code = 4'h0; arith = 1'b1; end
      4'b0010: begin code = 4'h2; arith = 1'b1; end
      4'b0000: code = 4'h4;
      4'b1100: code = 4'h5;
      4'b0001: code = 4'h6;
      4'b1101: code = 4'h7;
      4'b1110: code = 4'h8;
      4'b1010: begin code = 4'h2; nw = 1'b1; arith = 1'b1; end
      4'b1011: begin code = 4'h0; nw = 1'b1; arith = 1'b1; end
      4'b1000: begin code = 4'h4; nw = 1'b1; end
      4'b1001: begin code = 4'h6; nw = 1'b1; end
      default: legal = 1'b0;
    endcase
  endfunction

  // Expected per-cycle outputs for one whole instruction
  function automatic void model(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                                input bit ism, input int lat, input bit c3, input bit c1);
    logic [1:0] rsrc;
    logic [7:0] il;
    logic [7:0] wpc;
    logic [3:0] code;
    bit         nw, legal, arith, nc;
    string      en;
    rsrc = (op == 2'b01) ? 2'b10 : ((op == 2'b00) ? 2'b00 : 2'b01);
    wpc  = (rd == 4'd15) ? F_PCS : 8'h00;
    dp_info(f[4:1], code, nw, legal, arith);
    nc = (op == 2'b11) || (op == 2'b00 && !ism && !legal);
    il = nc ? F_ILL : 8'h00;
    en = f[5] ? "executei" : "executer";
    push("fetch", mk(F_IRW | F_NPC | (carry ? F_ILL : 8'h00), 2'b10, 2'b01, 2'b10, op, rsrc, 2'b00, 4'h0), c3, c1);
    push("decode", mk(8'h00, 2'b10, 2'b01, 2'b10, op, rsrc, 2'b00, 4'h0), c3, c1);
    if (op == 2'b01) begin
      push("memadr", mk(il, 2'b00, 2'b00, 2'b01, op, rsrc, 2'b00, 4'h0), c3, c1);
      if (f[0]) begin
        push("memrd", mk(F_ADR | il, 2'b00, 2'b00, 2'b00, op, rsrc, 2'b00, 4'h0), c3, c1);
        push("memwb", mk(F_REGW | wpc | il, 2'b01, 2'b00, 2'b00, op, rsrc, 2'b00, 4'h0), c3, c1);
      end else begin
        push("memwr", mk(F_ADR | F_MEMW | il, 2'b00, 2'b00, 2'b00, op, rsrc, 2'b00, 4'h0), c3, c1);
      end
    end else if (op == 2'b10) begin
      push("branch", mk(F_PCS | il, 2'b10, 2'b00, 2'b01, op, rsrc, 2'b00, 4'h0), c3, c1);
    end else if (op == 2'b00 && ism) begin
      for (int k = 0; k < lat; k++)
        push("mulex", mk(((k == 0) ? F_MS : 8'h00) | il, 2'b00, 2'b00, 2'b00, op, rsrc, {f[0], 1'b0}, 4'h9), c3, c1);
      push("aluwb", mk(F_REGW | wpc | il, 2'b00, 2'b00, 2'b00, op, rsrc, 2'b00, 4'h0), c3, c1);
    end else if (op == 2'b00) begin
      if (legal)
        push(en, mk(il, 2'b00, 2'b00, f[5] ? 2'b01 : 2'b00, op, rsrc,
                    nw ? {1'b1, arith} : {f[0], f[0] & arith}, code), c3, c1);
      else
        push(en, mk(il, 2'b00, 2'b00, f[5] ? 2'b01 : 2'b00, op, rsrc, 2'b00, 4'h0), c3, c1);
      if (legal && !nw)
        push("aluwb", mk(F_REGW | wpc | il, 2'b00, 2'b00, 2'b00, op, rsrc, 2'b00, 4'h0), c3, c1);
    end
    carry = nc;
  endfunction

  task automatic clear();
    expq.delete(); obs3q.delete(); obs1q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    carry = 1'b0;
    sync1 = 1'b1;
  endtask

  // Holds one instruction on the fields and samples both DUTs every cycle;
  // abortAt >= 0 raises reset during that cycle and samples the FETCH after it
  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                               input bit ism, input int abortAt, input bit lat1);
    int start;
    int n;
    start = expq.size();
    Op = op; Funct = f; Rd = rd; IsMul = ism;
    model(op, f, rd, ism, lat1 ? 1 : 3, !lat1, lat1 || (sync1 && !ism));
    n = expq.size() - start;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      obs3q.push_back(obs3());
      obs1q.push_back(obs1());
      if (i == abortAt) begin
        while (expq.size() > start + i + 1) void'(expq.pop_back());
        reset = 1'b1;
        @(negedge clk);
        #1;
        carry = 1'b0;
        push("reset_fetch", mk(F_IRW | F_NPC, 2'b10, 2'b01, 2'b10, op,
             (op == 2'b01) ? 2'b10 : ((op == 2'b00) ? 2'b00 : 2'b01), 2'b00, 4'h0), 1'b1, 1'b1);
        obs3q.push_back(obs3());
        obs1q.push_back(obs1());
        reset = 1'b0;
        sync1 = 1'b1;
        return;
      end
    end
    if (ism && !lat1) sync1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [24:0] want;
    Op = 2'b00; Funct = 6'd0; Rd = 4'd0; IsMul = 1'b0;
    do_reset();
    #1;
    want = mk(F_IRW | F_NPC, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 4'h0);
    tests++; if (obs3() !== want) begin fails++; $display("[TB] FAIL reset dut3 got %h want %h", obs3(), want); end
    tests++; if (obs1() !== want) begin fails++; $display("[TB] FAIL reset dut1 got %h want %h", obs1(), want); end
  endtask

  task automatic test_ldr();
    clear();
    applyStimulus(2'b01, 6'b011001, 4'd3, 1'b0, -1, 1'b0);
    applyStimulus(2'b01, 6'b011001, 4'd15, 1'b0, -1, 1'b0);
    foreach (expq[i]) begin
      if (expq[i].c3) begin tests++; if (obs3q[i] !== expq[i].v) begin fails++; $display("[TB] FAIL ldr/%s dut3 got %h want %h", expq[i].name, obs3q[i], expq[i].v); end end
      if (expq[i].c1) begin tests++; if (obs1q[i] !== expq[i].v) begin fails++; $display("[TB] FAIL ldr/%s dut1 got %h want %h", expq[i].name, obs1q[i], expq[i].v); end end
    end
  endtask

  task automatic test_adds();
    clear();
    applyStimulus(2'b00, 6'b001001, 4'd4, 1'b0, -1, 1'b0);
    applyStimulus(2'b00, 6'b001001, 4'd15, 1'b0, -1, 1'b0);
    applyStimulus(2'b00, 6'b111011, 4'd2, 1'b0, -1, 1'b0);
    foreach (expq[i]) begin
      if (expq[i].c3) begin tests++; if (obs3q[i] !== expq[i].v) begin fails++; $display("[TB] FAIL adds/%s dut3 got %h want %h", expq[i].name, obs3q[i], expq[i].v); end end
      if (expq[i].c1) begin tests++; if (obs1q[i] !== expq[i].v) begin fails++; $display("[TB] FAIL adds/%s dut1 got %h want %h", expq[i].name, obs1q[i], expq[i].v); end end
    end
  endtask

  task automatic test_cmp();
    int regw;
    clear();
    applyStimulus(2'b00, 6'b010101, 4'd15, 1'b0, -1, 1'b0);
    applyStimulus(2'b00, 6'b110000, 4'd1, 1'b0, -1, 1'b0);
    regw = 0;
    foreach (expq[i]) begin
      if (obs3q[i][21]) regw++;
      if (expq[i].c3) begin tests++; if (obs3q[i] !== expq[i].v) begin fails++; $display("[TB] FAIL cmp/%s dut3 got %h want %h", expq[i].name, obs3q[i], expq[i].v); end end
      if (expq[i].c1) begin tests++; if (obs1q[i] !== expq[i].v) begin fails++; $display("[TB] FAIL cmp/%s dut1 got %h want %h", expq[i].name, obs1q[i], expq[i].v); end end
    end
    tests++; if (regw !== 0) begin fails++; $display("[TB] FAIL cmp_regw cycles got %0d want 0", regw); end
  endtask

  task automatic test_mul_lat3();
    int starts, mulCycles;
    clear();
    applyStimulus(2'b00, 6'b000001, 4'd5, 1'b1, -1, 1'b0);
    starts = 0; mulCycles = 0;
    foreach (expq[i]) begin
      if (obs3q[i][18]) starts++;
      if (obs3q[i][4:0] == 5'd9) mulCycles++;
      if (expq[i].c3) begin tests++; if (obs3q[i] !== expq[i].v) begin fails++; $display("[TB] FAIL mul3/%s dut3 got %h want %h", expq[i].name, obs3q[i], expq[i].v); end end
    end
    tests++; if (starts !== 1) begin fails++; $display("[TB] FAIL mul3_start pulses got %0d want 1", starts); end
    tests++; if (mulCycles !== 3) begin fails++; $display("[TB] FAIL mul3_cycles got %0d want 3", mulCycles); end
    do_reset();
  endtask

  task automatic test_mul_lat1();
    int starts, mulCycles;
    clear();
    applyStimulus(2'b00, 6'b000000, 4'd15, 1'b1, -1, 1'b1);
    starts = 0; mulCycles = 0;
    foreach (expq[i]) begin
      if (obs1q[i][18]) starts++;
      if (obs1q[i][4:0] == 5'd9) mulCycles++;
      if (expq[i].c1) begin tests++; if (obs1q[i] !== expq[i].v) begin fails++; $display("[TB] FAIL mul1/%s dut1 got %h want %h", expq[i].name, obs1q[i], expq[i].v); end end
    end
    tests++; if (starts !== 1) begin fails++; $display("[TB] FAIL mul1_start pulses got %0d want 1", starts); end
    tests++; if (mulCycles !== 1) begin fails++; $display("[TB] FAIL mul1_cycles got %0d want 1", mulCycles); end
    do_reset();
  endtask

  task automatic test_illegal();
    int ill;
    clear();
    applyStimulus(2'b00, 6'b001110, 4'd6, 1'b0, -1, 1'b0);
    applyStimulus(2'b00, 6'b001000, 4'd7, 1'b0, -1, 1'b0);
    applyStimulus(2'b11, 6'b101011, 4'd15, 1'b0, -1, 1'b0);
    applyStimulus(2'b01, 6'b011000, 4'd2, 1'b0, -1, 1'b0);
    ill = 0;
    foreach (expq[i]) begin
      if (obs3q[i][17]) ill++;
      if (expq[i].c3) begin tests++; if (obs3q[i] !== expq[i].v) begin fails++; $display("[TB] FAIL illegal/%s dut3 got %h want %h", expq[i].name, obs3q[i], expq[i].v); end end
      if (expq[i].c1) begin tests++; if (obs1q[i] !== expq[i].v) begin fails++; $display("[TB] FAIL illegal/%s dut1 got %h want %h", expq[i].name, obs1q[i], expq[i].v); end end
    end
    tests++; if (ill !== 3) begin fails++; $display("[TB] FAIL illegal_cycles got %0d want 3", ill); end
  endtask

  task automatic test_reset_midop();
    int mulCycles;
    clear();
    applyStimulus(2'b00, 6'b000001, 4'd8, 1'b1, 3, 1'b0);
    applyStimulus(2'b01, 6'b011000, 4'd9, 1'b0, 3, 1'b0);
    applyStimulus(2'b00, 6'b000001, 4'd15, 1'b1, -1, 1'b0);
    mulCycles = 0;
    foreach (expq[i]) begin
      if (i >= 10 && obs3q[i][4:0] == 5'd9) mulCycles++;
      if (expq[i].c3) begin tests++; if (obs3q[i] !== expq[i].v) begin fails++; $display("[TB] FAIL midreset/%s dut3 got %h want %h", expq[i].name, obs3q[i], expq[i].v); end end
      if (expq[i].c1) begin tests++; if (obs1q[i] !== expq[i].v) begin fails++; $display("[TB] FAIL midreset/%s dut1 got %h want %h", expq[i].name, obs1q[i], expq[i].v); end end
    end
    tests++; if (mulCycles !== 3) begin fails++; $display("[TB] FAIL midreset_mul_cycles got %0d want 3", mulCycles); end
    do_reset();
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [5:0] f;
    logic [3:0] rd;
    bit         ism;
    for (int r = 0; r < 5; r++) begin
      do_reset();
      clear();
      for (int n = 0; n < 8; n++) begin
        op  = 2'($urandom_range(0, 3));
        f   = 6'($urandom);
        rd  = 4'($urandom);
        ism = (op == 2'b00) && ($urandom_range(0, 3) == 0);
        if (ism) f[5:4] = 2'b00;
        applyStimulus(op, f, rd, ism, -1, 1'b0);
      end
      foreach (expq[i]) begin
        if (expq[i].c3) begin tests++; if (obs3q[i] !== expq[i].v) begin fails++; $display("[TB] FAIL random/%s dut3 got %h want %h", expq[i].name, obs3q[i], expq[i].v); end end
        if (expq[i].c1) begin tests++; if (obs1q[i] !== expq[i].v) begin fails++; $display("[TB] FAIL random/%s dut1 got %h want %h", expq[i].name, obs1q[i], expq[i].v); end end
      end
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    reset = 1'b1;
    test_reset();
    test_ldr();
    test_adds();
    test_cmp();
    test_mul_lat3();
    test_mul_lat1();
    test_illegal();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired after %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
